ps_rr_arbiter: RTL and testbench

- Parametrised, registered successor to the ps2/ps4/ps8 priority selector chain.
- Arbitrates N requesters onto one registered one-hot grant. Supports two modes:
  - fixed priority: highest index wins, same ordering as the ps chain;
  - round-robin: rotating pointer, with a bounded grant hold.
- Keeps the en / req_up cascade semantics so instances can chain like ps blocks.
- Sits in front of shared-resource ports (e.g. issue/CDB) needing fairness.

---
 rtl/ps_arb_pkg.sv | 26 ++
 rtl/ps_rr_arbiter_if.sv | 34 +++
 rtl/ps_prio_enc.sv | 24 ++
 rtl/ps_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_ps_rr_arbiter.sv | 137 +++++++++++++
 5 files changed

// File: rtl/ps_arb_pkg.sv
// Shared types and helpers for the ps_rr_arbiter slice.
// Contents: arb_mode_t (fixed / round-robin select), SWITCH_CNT_W (width of
// the optional switch counter enabled by ARB_STATS_EN), and onehot_to_idx.
package ps_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  localparam int unsigned SWITCH_CNT_W = 16;

  // Upper bound on requester count that onehot_to_idx can encode.
  localparam int unsigned MAX_N = 256;

  // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ps_rr_arbiter_if.sv
// Request/grant bundle between requesters and ps_rr_arbiter.
// Signals: req/en/mode (requester side), gnt/gnt_valid/gnt_idx (registered
// grant), req_up (combinational cascade enable), switch_cnt (only when
// ARB_STATS_EN is defined).
// Modports: master = requester side, slave = arbiter side.
interface ps_rr_arbiter_if
  import ps_arb_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
);

  logic [N-1:0]     req;
  logic             en;
  arb_mode_t        mode;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             req_up;
`ifdef ARB_STATS_EN
  logic [SWITCH_CNT_W-1:0] switch_cnt;

  modport master (output req, en, mode,
                  input  gnt, gnt_valid, gnt_idx, req_up, switch_cnt);
  modport slave  (input  req, en, mode,
                  output gnt, gnt_valid, gnt_idx, req_up, switch_cnt);
`else
  modport master (output req, en, mode,
                  input  gnt, gnt_valid, gnt_idx, req_up);
  modport slave  (input  req, en, mode,
                  output gnt, gnt_valid, gnt_idx, req_up);
`endif

endinterface

// File: rtl/ps_prio_enc.sv
// Combinational highest-index-first priority encoder.
// Ports: req (N request bits), gnt_c (one-hot of highest set bit, or zero),
// valid_c (any request set).
module ps_prio_enc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt_c,
  output logic         valid_c
);

  // Ascending scan: the last (highest) set bit overwrites earlier ones.
  always_comb begin
    gnt_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) begin
        gnt_c    = '0;
        gnt_c[i] = 1'b1;
      end
    end
    valid_c = |req;
  end

endmodule

// File: rtl/ps_rr_arbiter.sv
// Registered N-way arbiter with fixed-priority and round-robin modes,
// cascadable through en/req_up like the ps2/ps4/ps8 selector chain.
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   bus (slave)     req/en/mode in; gnt/gnt_valid/gnt_idx registered out;
//                   req_up = en & ~|req combinational out
// Optional: define ARB_STATS_EN to add bus.switch_cnt, a saturating count of
// edges where the grant moves between two different non-zero values.
module ps_rr_arbiter
  import ps_arb_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned IDX_W    = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  ps_rr_arbiter_if.slave bus
);

  localparam int unsigned HOLD_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  // Saturation point of hold_q; MAX_HOLD == 0 means the limit never applies.
  localparam logic [HOLD_W-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(HOLD_LAST_I);
  localparam logic [IDX_W-1:0] PTR_TOP = IDX_W'(N - 1);

  logic [N-1:0]      gnt_q, gnt_d;
  logic              gnt_valid_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [N-1:0]      scan_mask, masked_req;
  logic [N-1:0]      fb_gnt, msk_gnt, sel_gnt;
  logic              fb_valid, msk_valid;
  logic [IDX_W-1:0]  scan_start, sel_idx;
  logic              has_holder, holder_req, others_req, keep;

  // Holder status against the current request vector.
  assign has_holder = |gnt_q;
  assign holder_req = |(gnt_q & bus.req);
  assign others_req = |(bus.req & ~gnt_q);
  assign keep       = holder_req &&
                      ((MAX_HOLD == 0) || (hold_q < HOLD_SAT) || !others_req);

  // With a holder the scan starts just below rr_ptr so the holder ranks last.
  always_comb begin
    scan_start = rr_ptr_q;
    if (has_holder) begin
      scan_start = (rr_ptr_q == '0) ? PTR_TOP : rr_ptr_q - IDX_W'(1);
    end
  end

  // Keep only bits at or below the scan start; the unmasked encoder covers the wrap.
  always_comb begin
    scan_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_mask[i] = (IDX_W'(i) <= scan_start);
    end
  end

  assign masked_req = bus.req & scan_mask;

  ps_prio_enc #(.N(N)) u_enc_all (
    .req     (bus.req),
    .gnt_c   (fb_gnt),
    .valid_c (fb_valid)
  );

  ps_prio_enc #(.N(N)) u_enc_masked (
    .req     (masked_req),
    .gnt_c   (msk_gnt),
    .valid_c (msk_valid)
  );

  assign sel_gnt = msk_valid ? msk_gnt : fb_gnt;
  assign sel_idx = IDX_W'(onehot_to_idx(MAX_N'(sel_gnt)));

  // Next grant, pointer and hold count.
  always_comb begin
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    if (!bus.en || !fb_valid) begin
      gnt_d  = '0;
      hold_d = '0;
    end else if (bus.mode == ARB_FIXED) begin
      gnt_d  = fb_gnt;
      hold_d = '0;
    end else if (keep) begin
      gnt_d = gnt_q;
      if (hold_q != HOLD_SAT) hold_d = hold_q + HOLD_W'(1);
    end else begin
      gnt_d    = sel_gnt;
      rr_ptr_d = sel_idx;
      hold_d   = '0;
    end
  end

  assign idx_d = IDX_W'(onehot_to_idx(MAX_N'(gnt_d)));

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      idx_q       <= '0;
      rr_ptr_q    <= PTR_TOP;
      hold_q      <= '0;
    end else begin
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.req_up    = bus.en & ~(|bus.req);

`ifdef ARB_STATS_EN
  logic [SWITCH_CNT_W-1:0] switch_cnt_q;

  // Count only moves between two different live grants.
  always_ff @(posedge clock) begin
    if (reset) begin
      switch_cnt_q <= '0;
    end else if ((|gnt_q) && (|gnt_d) && (gnt_d != gnt_q) &&
                 (switch_cnt_q != {SWITCH_CNT_W{1'b1}})) begin
      switch_cnt_q <= switch_cnt_q + SWITCH_CNT_W'(1);
    end
  end

  assign bus.switch_cnt = switch_cnt_q;
`endif

endmodule

// File: tb/tb_ps_rr_arbiter.sv
// Self-checking bench for ps_rr_arbiter (N=8, MAX_HOLD=4).
module tb_ps_rr_arbiter;
  import ps_arb_pkg::*;

  logic clk;
  logic rst;

  ps_rr_arbiter_if #(.N(8)) bus ();

  ps_rr_arbiter #(.N(8), .MAX_HOLD(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic      rst;
    logic      en;
    arb_mode_t mode;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       req_up;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input arb_mode_t m, input logic [7:0] q);
    rst      = r;
    bus.en   = e;
    bus.mode = m;
    bus.req  = q;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] i,
                           input logic up);
    check({tag, ".gnt"},       32'(bus.gnt),       32'(g));
    check({tag, ".gnt_idx"},   32'(bus.gnt_idx),   32'(i));
    check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(|g));
    check({tag, ".req_up"},    32'(bus.req_up),    32'(up));
  endtask

  initial begin
    int exp_i;
    logic [7:0] exp_g;

    drive(1'b1, 1'b0, ARB_FIXED, 8'h00);

    //          rst   en    mode       req    gnt    idx   req_up
    vecs[0]  = '{1'b1, 1'b0, ARB_FIXED, 8'h00, 8'h00, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, ARB_FIXED, 8'h00, 8'h00, 3'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, ARB_FIXED, 8'h26, 8'h20, 3'd5, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, ARB_FIXED, 8'h26, 8'h20, 3'd5, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, ARB_FIXED, 8'h26, 8'h20, 3'd5, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, ARB_FIXED, 8'h81, 8'h80, 3'd7, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, ARB_FIXED, 8'h01, 8'h01, 3'd0, 1'b0};
    // RR with stale holder 0 and rr_ptr 7: scan from 6 down picks 4.
    vecs[7]  = '{1'b0, 1'b1, ARB_RR,    8'h10, 8'h10, 3'd4, 1'b0};
    // Reset mid-grant clears the grant and returns rr_ptr to 7.
    vecs[8]  = '{1'b1, 1'b1, ARB_RR,    8'h10, 8'h00, 3'd0, 1'b0};
    // No holder, scan from 7 inclusive: 7 wins (a stale ptr of 4 would pick 0).
    vecs[9]  = '{1'b0, 1'b1, ARB_RR,    8'h81, 8'h80, 3'd7, 1'b0};
    vecs[10] = '{1'b0, 1'b0, ARB_RR,    8'h81, 8'h00, 3'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, ARB_RR,    8'h00, 8'h00, 3'd0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, ARB_FIXED, 8'h00, 8'h00, 3'd0, 1'b0};

    tick();
    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].rst, vecs[v].en, vecs[v].mode, vecs[v].req);
      tick();
      check_out($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].idx, vecs[v].req_up);
    end

    // Round-robin with all requesting: four cycles each, 7 down to 0, then 7.
    drive(1'b1, 1'b0, ARB_RR, 8'h00);
    tick();
    for (int k = 0; k < 36; k++) begin
      drive(1'b0, 1'b1, ARB_RR, 8'hFF);
      tick();
      exp_i = 7 - ((k / 4) % 8);
      exp_g = 8'h01 << exp_i;
      check($sformatf("rr_all.gnt[%0d]", k), 32'(bus.gnt), 32'(exp_g));
      check($sformatf("rr_all.idx[%0d]", k), 32'(bus.gnt_idx), 32'(exp_i));
`ifdef ARB_STATS_EN
      if (k == 31) check("switch_cnt", 32'(bus.switch_cnt), 32'd7);
`endif
    end

    // Sole requester keeps the grant past the hold limit.
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, ARB_RR, 8'h08);
      tick();
      check_out($sformatf("sole3[%0d]", k), 8'h08, 3'd3, 1'b0);
    end

    // Move grant to 6, then drop req[6]: grant moves to 0 with no bubble.
    drive(1'b0, 1'b1, ARB_RR, 8'h40);
    tick();
    check_out("to6", 8'h40, 3'd6, 1'b0);
    drive(1'b0, 1'b1, ARB_RR, 8'h41);
    tick();
    check_out("hold6", 8'h40, 3'd6, 1'b0);
    drive(1'b0, 1'b1, ARB_RR, 8'h01);
    tick();
    check_out("drop6", 8'h01, 3'd0, 1'b0);
    drive(1'b0, 1'b0, ARB_RR, 8'h82);
    tick();
    check_out("disable", 8'h00, 3'd0, 1'b0);
    // Re-enable: rr_ptr 0 not requesting, scan wraps to 7.
    drive(1'b0, 1'b1, ARB_RR, 8'h82);
    tick();
    check_out("reenable", 8'h80, 3'd7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
